// File: rtl/ca2_serial_alu.sv
// Digit-serial two's-complement NEG/ADD/SUB/CMP unit with a registered CVNZ condition code.
// Each clock adds one step-bit digit, LSB digit first, through a chain of full adders.
module ca2_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module ca2_serial_alu #(
   parameter int op_size = 4,
   parameter int step    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [op_size-1:0] A,
   input  logic [op_size-1:0] B,
   output logic [op_size-1:0] R,
   output logic [3:0]         CCR,
   output logic               busy,
   output logic               done
);
   localparam int N  = op_size / step;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] OP_NEG = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_CMP = 2'b11;

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nx;

   logic [CW-1:0]      cnt;
   logic [op_size-1:0] x_sh, y_sh, s_sh, s_nx;
   logic [1:0]         op_q;
   logic               carry;
   logic [step:0]      c;
   logic [step-1:0]    sum_d;
   logic               last;
   logic [3:0]         flags;

   assign c[0] = carry;
   for (genvar i = 0; i < step; i++) begin : g_fa
      ca2_fa u_fa (.a(x_sh[i]), .b(y_sh[i]), .ci(c[i]), .s(sum_d[i]), .co(c[i+1]));
   end

   // New digit enters at the top; after N shifts the full result is aligned.
   assign s_nx = op_size'({sum_d, s_sh} >> step);
   assign last = (state == RUN) && (cnt == CW'(N - 1));
   assign busy = (state == RUN);

   // Only meaningful on the last digit, where c[step-1] is the carry into the MSB.
   assign flags = {(op_q == OP_ADD) ? c[step] : ~c[step],
                   c[step] ^ c[step-1],
                   s_nx[op_size-1],
                   (s_nx == '0)};

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         R     <= '0;
         CCR   <= '0;
         done  <= 1'b0;
         cnt   <= '0;
         x_sh  <= '0;
         y_sh  <= '0;
         s_sh  <= '0;
         op_q  <= '0;
         carry <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            op_q <= op;
            cnt  <= '0;
            s_sh <= '0;
            // NEG is 0 + ~A + 1; SUB/CMP is A + ~B + 1.
            x_sh  <= (op == OP_NEG) ? '0 : A;
            y_sh  <= (op == OP_NEG) ? ~A : (op == OP_ADD) ? B : ~B;
            carry <= (op != OP_ADD);
         end else if (state == RUN) begin
            x_sh  <= x_sh >> step;
            y_sh  <= y_sh >> step;
            s_sh  <= s_nx;
            carry <= c[step];
            cnt   <= cnt + CW'(1);
            if (last) begin
               cnt  <= '0;
               done <= 1'b1;
               CCR  <= flags;
               if (op_q != OP_CMP) R <= s_nx;
            end
         end
      end
   end
endmodule

// File: tb/tb_ca2_serial_alu.sv
// Bench for ca2_serial_alu: three instances (4/1, 8/2, 8/4) checked against an arithmetic model.
module tb_ca2_serial_alu;
   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       start_v;
   logic [1:0]       op_i;
   logic [7:0]       a_i, b_i;
   logic [3:0]       r4;
   logic [7:0]       r8a, r8b;
   logic [2:0][3:0]  ccr_v;
   logic [2:0]       busy_v, done_v;
   logic [7:0]       exp_r [3];
   int               nlat  [3];
   int               wid   [3];
   int               checks = 0;
   int               errors = 0;

   typedef struct {
      logic [1:0] op;
      logic [7:0] a, b, r;
      logic [3:0] c;
   } vec_t;

   always #5 clk = ~clk;

   ca2_serial_alu #(.op_size(4), .step(1)) u4 (
      .clk(clk), .rst(rst), .start(start_v[0]), .op(op_i), .A(a_i[3:0]), .B(b_i[3:0]),
      .R(r4), .CCR(ccr_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   ca2_serial_alu #(.op_size(8), .step(2)) u8a (
      .clk(clk), .rst(rst), .start(start_v[1]), .op(op_i), .A(a_i), .B(b_i),
      .R(r8a), .CCR(ccr_v[1]), .busy(busy_v[1]), .done(done_v[1]));
   ca2_serial_alu #(.op_size(8), .step(4)) u8b (
      .clk(clk), .rst(rst), .start(start_v[2]), .op(op_i), .A(a_i), .B(b_i),
      .R(r8b), .CCR(ccr_v[2]), .busy(busy_v[2]), .done(done_v[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] get_r(input int d);
      case (d)
         0:       return {4'b0, r4};
         1:       return r8a;
         default: return r8b;
      endcase
   endfunction

   // Reference from signed/unsigned arithmetic; returns {R, C, V, N, Z}.
   function automatic logic [11:0] model(input int w, input logic [1:0] op,
                                         input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] rp);
      int m, ua, ub, sa, sb, us, ts;
      bit cf, vf;
      m  = 1 << w;
      ua = int'(a) % m;
      ub = int'(b) % m;
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      case (op)
         2'b00: begin ts = -sa;     us = (m - ua) % m;      cf = (ua != 0);     end
         2'b01: begin ts = sa + sb; us = (ua + ub) % m;     cf = (ua + ub >= m); end
         default: begin ts = sa - sb; us = (ua - ub + m) % m; cf = (ua < ub);   end
      endcase
      vf = (ts < -(m / 2)) || (ts > m / 2 - 1);
      return {(op == 2'b11) ? rp : 8'(us), cf, vf, (us >= m / 2), (us == 0)};
   endfunction

   task automatic launch(input int d, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      op_i = op; a_i = a; b_i = b;
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
   endtask

   // Called on the negedge right after the accepting edge; returns on the done negedge.
   task automatic wait_done(input int d, input logic [7:0] er, input logic [3:0] ec, input bit poke);
      int j = 0;
      while (!done_v[d] && j < nlat[d] + 4) begin
         chk("busy_run", 32'(busy_v[d]), 1);
         if (poke && j == 0) begin
            start_v[d] = 1'b1; op_i = ~op_i; a_i = 8'($urandom); b_i = 8'($urandom);
         end
         if (poke && j == 1) start_v[d] = 1'b0;
         @(negedge clk);
         j++;
      end
      start_v[d] = 1'b0;
      chk("latency", 32'(j), 32'(nlat[d]));
      chk("busy_done", 32'(busy_v[d]), 0);
      chk("R", 32'(get_r(d)), 32'(er));
      chk("CCR", 32'(ccr_v[d]), 32'(ec));
      exp_r[d] = er;
   endtask

   task automatic gap(input int d);
      @(negedge clk);
      chk("done_pulse", 32'(done_v[d]), 0);
   endtask

   task automatic run_vec(input int d, input vec_t v);
      gap(d);
      launch(d, v.op, v.a, v.b);
      wait_done(d, v.r, v.c, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t dv4 [6];
      vec_t dv8 [3];
      logic [11:0] m;
      logic [7:0]  ra, rb, mask;
      logic [1:0]  rop;

      nlat = '{4, 4, 2};
      wid  = '{4, 8, 8};
      dv4 = '{'{2'b00, 8'h05, 8'h00, 8'h0b, 4'b1010},
              '{2'b00, 8'h08, 8'h00, 8'h08, 4'b1110},
              '{2'b00, 8'h00, 8'h00, 8'h00, 4'b0001},
              '{2'b01, 8'h07, 8'h01, 8'h08, 4'b0110},
              '{2'b10, 8'h03, 8'h05, 8'h0e, 4'b1010},
              '{2'b11, 8'h06, 8'h06, 8'h0e, 4'b0001}};
      dv8 = '{'{2'b00, 8'h80, 8'h00, 8'h80, 4'b1110},
              '{2'b00, 8'h05, 8'h00, 8'hfb, 4'b1010},
              '{2'b01, 8'h7f, 8'h01, 8'h80, 4'b0110}};

      rst = 1'b1; start_v = '0; op_i = '0; a_i = '0; b_i = '0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_R", 32'(get_r(d)), 0);
         chk("rst_CCR", 32'(ccr_v[d]), 0);
         chk("rst_busy", 32'(busy_v[d]), 0);
         chk("rst_done", 32'(done_v[d]), 0);
         exp_r[d] = '0;
      end
      rst = 1'b0;

      foreach (dv4[i]) run_vec(0, dv4[i]);

      // start while busy is ignored and not queued; inputs changing mid-run are ignored
      for (int d = 0; d < 3; d++) begin
         gap(d);
         launch(d, 2'b01, 8'h02, 8'h03);
         wait_done(d, 8'h05, 4'b0000, 1'b1);
         for (int k = 0; k < nlat[d] + 2; k++) begin
            @(negedge clk);
            chk("no_queue_done", 32'(done_v[d]), 0);
            chk("no_queue_busy", 32'(busy_v[d]), 0);
         end
      end

      // start on the done cycle is accepted
      gap(0);
      launch(0, 2'b10, 8'h01, 8'h02);
      wait_done(0, 8'h0f, 4'b1010, 1'b0);
      launch(0, 2'b00, 8'h07, 8'h00);
      wait_done(0, 8'h09, 4'b1010, 1'b0);

      // reset two cycles into RUN discards the operation
      gap(0);
      launch(0, 2'b00, 8'h03, 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_R", 32'(get_r(0)), 0);
      chk("midrst_CCR", 32'(ccr_v[0]), 0);
      chk("midrst_busy", 32'(busy_v[0]), 0);
      chk("midrst_done", 32'(done_v[0]), 0);
      rst = 1'b0;
      for (int d = 0; d < 3; d++) exp_r[d] = '0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("midrst_nodone", 32'(done_v[0]), 0);
      end
      run_vec(0, '{2'b00, 8'h01, 8'h00, 8'h0f, 4'b1010});

      for (int d = 1; d < 3; d++) foreach (dv8[i]) run_vec(d, dv8[i]);

      for (int d = 0; d < 3; d++) begin
         mask = 8'((1 << wid[d]) - 1);
         @(negedge clk);
         for (int t = 0; t < 25; t++) begin
            rop = 2'($urandom);
            ra  = 8'($urandom) & mask;
            rb  = 8'($urandom) & mask;
            if (t % 5 == 0) ra = 8'(1 << (wid[d] - 1));
            m = model(wid[d], rop, ra, rb, exp_r[d]);
            launch(d, rop, ra, rb);
            wait_done(d, m[11:4], m[3:0], 1'($urandom));
            if ($urandom_range(0, 1) == 1) gap(d);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
